cic_agc: RTL and testbench
==========================

# cic_agc

Automatic gain controller for the CIC decimator's 8-bit Gain (output shift) input. Watches the 12-bit decimated output and its sample clock, measures windowed peak magnitude, and steps Gain down fast on overload and up slowly on weak signal, with a settle interval after each change. Sits between the CIC output and the demodulator, in the osc_clk domain. A manual mode passes a register-supplied gain straight through.

## Interface
- WINDOW_LOG2, 10: measurement window is 2^WINDOW_LOG2 output samples
- GAIN_MIN, 0: lowest gain driven
- GAIN_MAX, 52: highest gain driven (CIC width - 12)
- GAIN_INIT, 20: gain after reset
- HI_THRESH, 1536: window peak above this gives gain -1
- LO_THRESH, 384: window peak below this counts toward gain +1
- HOLD_WINDOWS, 4: consecutive low windows required for gain +1
- SETTLE_SAMPLES, 2: output samples ignored after any gain change

- osc_clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- d_clk  in  1  CIC output sample clock (level, high about half of each output period)
- d_in  in  12 signed  CIC d_out; valid while d_clk is high
- agc_en  in  1  1 = automatic, 0 = manual
- manual_gain  in  8  gain used in manual mode
- gain  out  8  drives the CIC Gain input
- gain_upd  out  1  one-cycle pulse in the cycle gain takes a new value
- clip  out  1  one-cycle pulse per full-scale sample while in AGC mode
- peak  out  11  peak magnitude of the last completed window

## Operation
- Sample event: d_clk is registered into d_clk_q; event = d_clk & ~d_clk_q. d_in is captured with the event.
- Magnitude: abs(d_in), saturating, so -2048 maps to 2047. Full scale is magnitude 2047.
- States: MANUAL, MEASURE, DECIDE, SETTLE.
- Reset: state MANUAL, gain=GAIN_INIT, gain_upd=0, clip=0, peak=0, window peak/count=0, hold count=0, settle count=0.
- MANUAL
  - gain <= clamp(manual_gain, GAIN_MIN, GAIN_MAX) every cycle.
  - gain_upd pulses when the registered value changes.
  - agc_en=1: go to MEASURE with window peak, count and hold cleared. gain is kept.
- MEASURE: on each event, wpeak <= max(wpeak, mag) and count +1.
  - Full-scale event: next cycle clip=1.
    - If gain>GAIN_MIN: gain -1, gain_upd=1, hold=0, go to SETTLE.
    - If gain==GAIN_MIN: no gain change, but the window is still cleared and the state goes to SETTLE.
  - Event that completes the window (count reaches 2^WINDOW_LOG2): go to DECIDE.
  - A clip on the window-completing event takes priority and the window is discarded.
- DECIDE (one cycle): peak <= wpeak (this load also happens on a window discarded by clip). Then:
  - wpeak > HI_THRESH and gain > GAIN_MIN: gain -1, hold=0.
  - wpeak < LO_THRESH: hold +1. When hold reaches HOLD_WINDOWS and gain < GAIN_MAX: gain +1, hold=0. At GAIN_MAX, hold saturates at HOLD_WINDOWS.
  - Otherwise: hold=0.
  - If gain changed: gain_upd=1, go to SETTLE. Else go to MEASURE. The window is cleared in both cases.
- SETTLE: count SETTLE_SAMPLES events, then go to MEASURE with the window cleared. Full-scale events here still pulse clip but never change gain.
- agc_en=0 in any AGC state: go to MANUAL on the next cycle. The partial window is abandoned.
- Arithmetic:
  - gain never leaves [GAIN_MIN, GAIN_MAX].
  - The window counter is WINDOW_LOG2+1 bits.
  - Comparisons are unsigned on 11-bit magnitude.

## Timing
- Event detection adds 1 cycle after the d_clk rising edge.
- Clip response: clip and the new gain appear 1 cycle after the event cycle.
- Window-end response: DECIDE is the cycle after the final event; the new gain and gain_upd appear on the following cycle.
- gain_upd and clip are single-cycle pulses and never stretch.
- A d_clk held high produces only one event.
- At most one gain step per window or per clip.
- Manual mode: gain follows manual_gain with 1 cycle latency.
- Reset asserted mid-window or mid-settle returns all state and outputs to reset values on the next edge.

## Test plan
- Reset, agc_en=1, constant d_in=1000 for 1024 events -> peak=1000, no gain_upd, state returns to MEASURE.
- Gain 20, one window with d_in=1800 -> gain=19, gain_upd pulse 2 cycles after the final event, next 2 events ignored.
- d_in=-2048 on event 5 of a window -> clip pulse, gain 20->19 next cycle, window discarded, peak loaded with 2047.
- d_in=100 for 4 consecutive windows -> gain unchanged after windows 1-3, gain=21 after window 4. A 1000 window in between resets hold.
- Boundaries: gain=GAIN_MAX with low signal -> no change. gain=GAIN_MIN with clipping -> clip pulses, gain stays 0.
- Manual mode:
  - agc_en=0 with manual_gain=60 -> gain=52.
  - agc_en dropped mid-window -> MANUAL next cycle.
  - rst mid-SETTLE -> gain=20, all pulses 0.

Source files
------------

// File: rtl/cic_agc.sv
// Automatic gain control for the CIC decimator output shift: windowed peak tracking,
// fast gain reduction on overload, slow increase on weak signal, and a manual bypass.
module cic_agc #(
    parameter int WINDOW_LOG2    = 10,
    parameter int GAIN_MIN       = 0,
    parameter int GAIN_MAX       = 52,
    parameter int GAIN_INIT      = 20,
    parameter int HI_THRESH      = 1536,
    parameter int LO_THRESH      = 384,
    parameter int HOLD_WINDOWS   = 4,
    parameter int SETTLE_SAMPLES = 2
) (
    input  logic               osc_clk,
    input  logic               rst,
    input  logic               d_clk,
    input  logic signed [11:0] d_in,
    input  logic               agc_en,
    input  logic        [7:0]  manual_gain,
    output logic        [7:0]  gain,
    output logic               gain_upd,
    output logic               clip,
    output logic        [10:0] peak
);

    localparam int CW = WINDOW_LOG2 + 1;
    localparam int HW = $clog2(HOLD_WINDOWS + 1);
    localparam int SW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

    localparam logic [CW-1:0] WIN_LAST    = CW'((1 << WINDOW_LOG2) - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_N      = HW'(HOLD_WINDOWS);
    localparam logic [7:0]    G_MIN       = 8'(GAIN_MIN);
    localparam logic [7:0]    G_MAX       = 8'(GAIN_MAX);
    localparam logic [7:0]    G_INIT      = 8'(GAIN_INIT);
    localparam logic [10:0]   HI          = 11'(HI_THRESH);
    localparam logic [10:0]   LO          = 11'(LO_THRESH);
    localparam logic [10:0]   FULL        = 11'h7FF;

    typedef enum logic [1:0] {MANUAL, MEASURE, DECIDE, SETTLE} state_t;

    state_t         state;
    logic           d_clk_q;
    logic [10:0]    wpeak;
    logic [CW-1:0]  count;
    logic [HW-1:0]  hold;
    logic [SW-1:0]  settle_cnt;

    logic           sample_ev;
    logic           full;
    logic [10:0]    mag;
    logic [10:0]    wpeak_next;
    logic [7:0]     man_gain;
    logic [7:0]     dec_gain;
    logic [HW-1:0]  hold_inc;
    logic [HW-1:0]  dec_hold;

    // -2048 has no positive twin in 12 bits, so it saturates to full scale
    always_comb begin
        sample_ev = d_clk & ~d_clk_q;
        if (d_in == 12'sh800)
            mag = FULL;
        else if (d_in[11])
            mag = 11'(-d_in);
        else
            mag = d_in[10:0];
        full       = (mag == FULL);
        wpeak_next = (mag > wpeak) ? mag : wpeak;

        if (int'(manual_gain) < GAIN_MIN)
            man_gain = G_MIN;
        else if (int'(manual_gain) > GAIN_MAX)
            man_gain = G_MAX;
        else
            man_gain = manual_gain;

        hold_inc = hold + HW'(1);
        dec_gain = gain;
        dec_hold = '0;
        if (wpeak > HI && gain > G_MIN) begin
            dec_gain = gain - 8'd1;
        end else if (wpeak < LO) begin
            if (hold_inc >= HOLD_N) begin
                if (gain < G_MAX)
                    dec_gain = gain + 8'd1;
                else
                    dec_hold = HOLD_N;
            end else begin
                dec_hold = hold_inc;
            end
        end
    end

    always_ff @(posedge osc_clk) begin
        if (rst) begin
            state      <= MANUAL;
            d_clk_q    <= 1'b0;
            gain       <= G_INIT;
            gain_upd   <= 1'b0;
            clip       <= 1'b0;
            peak       <= '0;
            wpeak      <= '0;
            count      <= '0;
            hold       <= '0;
            settle_cnt <= '0;
        end else begin
            d_clk_q  <= d_clk;
            gain_upd <= 1'b0;
            clip     <= 1'b0;
            if (state == MANUAL) begin
                if (agc_en) begin
                    state <= MEASURE;
                    wpeak <= '0;
                    count <= '0;
                    hold  <= '0;
                end else begin
                    gain     <= man_gain;
                    gain_upd <= (man_gain != gain);
                end
            end else if (!agc_en) begin
                state <= MANUAL;
            end else begin
                case (state)
                    MEASURE: begin
                        if (sample_ev) begin
                            // Overload wins over window completion; the window is thrown away
                            if (full) begin
                                clip       <= 1'b1;
                                peak       <= wpeak_next;
                                wpeak      <= '0;
                                count      <= '0;
                                settle_cnt <= '0;
                                state      <= SETTLE;
                                if (gain > G_MIN) begin
                                    gain     <= gain - 8'd1;
                                    gain_upd <= 1'b1;
                                    hold     <= '0;
                                end
                            end else begin
                                wpeak <= wpeak_next;
                                count <= count + CW'(1);
                                if (count == WIN_LAST)
                                    state <= DECIDE;
                            end
                        end
                    end
                    DECIDE: begin
                        clip       <= sample_ev & full;
                        peak       <= wpeak;
                        wpeak      <= '0;
                        count      <= '0;
                        gain       <= dec_gain;
                        hold       <= dec_hold;
                        settle_cnt <= '0;
                        if (dec_gain != gain) begin
                            gain_upd <= 1'b1;
                            state    <= SETTLE;
                        end else begin
                            state <= MEASURE;
                        end
                    end
                    SETTLE: begin
                        if (sample_ev) begin
                            clip <= full;
                            if (settle_cnt == SETTLE_LAST) begin
                                state <= MEASURE;
                                wpeak <= '0;
                                count <= '0;
                            end else begin
                                settle_cnt <= settle_cnt + SW'(1);
                            end
                        end
                    end
                    default: state <= MANUAL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cic_agc.sv
// Directed bench for cic_agc: an event-level gain-control model predicts gain, peak and
// pulses each cycle, and literal expectations pin key points of the model.
module tb_cic_agc;

    localparam int WL      = 10;
    localparam int WIN     = 1 << WL;
    localparam int GMIN    = 0;
    localparam int GMAX    = 52;
    localparam int GINIT   = 20;
    localparam int HI      = 1536;
    localparam int LO      = 384;
    localparam int HOLDW   = 4;
    localparam int SETTLEN = 2;

    logic               osc_clk = 1'b0;
    logic               rst = 1'b0;
    logic               d_clk = 1'b0;
    logic signed [11:0] d_in = '0;
    logic               agc_en = 1'b1;
    logic        [7:0]  manual_gain = '0;
    logic        [7:0]  gain;
    logic               gain_upd;
    logic               clip;
    logic        [10:0] peak;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 0;

    int exp_gain = GINIT;
    int exp_peak = 0;
    bit exp_clip = 0;
    bit exp_upd = 0;

    bit in_manual = 0;
    bit settling = 0;
    bit decide_pending = 0;
    int wpeak = 0;
    int cnt = 0;
    int hold = 0;
    int settle_cnt = 0;

    cic_agc dut (
        .osc_clk(osc_clk),
        .rst(rst),
        .d_clk(d_clk),
        .d_in(d_in),
        .agc_en(agc_en),
        .manual_gain(manual_gain),
        .gain(gain),
        .gain_upd(gain_upd),
        .clip(clip),
        .peak(peak)
    );

    always #5 osc_clk = ~osc_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle away from the clock edge, the DUT must agree with the model
    always @(negedge osc_clk) begin
        if (chk_en) begin
            checkOutput("gain", 32'(gain), 32'(exp_gain));
            checkOutput("peak", 32'(peak), 32'(exp_peak));
            checkOutput("clip", 32'(clip), 32'(exp_clip));
            checkOutput("gain_upd", 32'(gain_upd), 32'(exp_upd));
        end
    end

    function automatic int clampg(input int g);
        if (g < GMIN) return GMIN;
        if (g > GMAX) return GMAX;
        return g;
    endfunction

    function automatic int magof(input int v);
        if (v == -2048) return 2047;
        return (v < 0) ? -v : v;
    endfunction

    task automatic tick();
        @(posedge osc_clk);
        #1;
        exp_clip = 0;
        exp_upd  = 0;
        if (in_manual) begin
            int ng;
            ng = clampg(int'(manual_gain));
            exp_upd  = (ng != exp_gain);
            exp_gain = ng;
        end
    endtask

    task automatic clear_window();
        wpeak = 0;
        cnt = 0;
        decide_pending = 0;
    endtask

    task automatic model_event(input int v);
        int m;
        m = magof(v);
        if (in_manual) return;
        if (settling) begin
            exp_clip = (m == 2047);
            settle_cnt++;
            if (settle_cnt == SETTLEN) begin
                settling = 0;
                clear_window();
            end
        end else if (m == 2047) begin
            exp_clip = 1;
            exp_peak = 2047;
            if (exp_gain > GMIN) begin
                exp_gain--;
                exp_upd = 1;
                hold = 0;
            end
            settling = 1;
            settle_cnt = 0;
            clear_window();
        end else begin
            if (m > wpeak) wpeak = m;
            cnt++;
            if (cnt == WIN) decide_pending = 1;
        end
    endtask

    task automatic model_decide();
        int g;
        g = exp_gain;
        exp_peak = wpeak;
        if (wpeak > HI && g > GMIN) begin
            g--;
            hold = 0;
        end else if (wpeak < LO) begin
            hold++;
            if (hold >= HOLDW) begin
                if (g < GMAX) begin
                    g++;
                    hold = 0;
                end else begin
                    hold = HOLDW;
                end
            end
        end else begin
            hold = 0;
        end
        if (g != exp_gain) begin
            exp_gain = g;
            exp_upd = 1;
            settling = 1;
            settle_cnt = 0;
        end
        clear_window();
    endtask

    // One CIC output sample: d_clk high for high_len cycles, then low for two
    task automatic applyStimulus(input int v, input int high_len);
        d_in  = 12'(v);
        d_clk = 1'b1;
        tick();
        model_event(v);
        tick();
        if (decide_pending) model_decide();
        for (int i = 2; i < high_len; i++) tick();
        d_clk = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_samples(input int v, input int n);
        for (int i = 0; i < n; i++) applyStimulus(v, 2);
    endtask

    task automatic do_reset();
        in_manual = 0;
        rst = 1'b1;
        tick();
        exp_gain = GINIT;
        exp_peak = 0;
        exp_clip = 0;
        exp_upd = 0;
        settling = 0;
        settle_cnt = 0;
        hold = 0;
        clear_window();
        chk_en = 1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic enter_manual(input int mg);
        manual_gain = 8'(mg);
        agc_en = 1'b0;
        tick();
        in_manual = 1;
        settling = 0;
        clear_window();
    endtask

    task automatic enter_agc();
        agc_en = 1'b1;
        in_manual = 0;
        tick();
        settling = 0;
        hold = 0;
        clear_window();
    endtask

    initial begin
        $display("[TB] cic_agc directed test start");
        do_reset();
        checkOutput("reset_gain_lit", 32'(gain), 32'd20);
        checkOutput("reset_peak_lit", 32'(peak), 32'd0);
        checkOutput("reset_clip_lit", 32'(clip), 32'd0);
        checkOutput("reset_upd_lit", 32'(gain_upd), 32'd0);

        send_samples(1000, WIN);
        checkOutput("mid_window_peak_lit", 32'(peak), 32'd1000);
        checkOutput("mid_window_gain_lit", 32'(gain), 32'd20);

        send_samples(1800, WIN);
        checkOutput("hi_window_gain_lit", 32'(gain), 32'd19);
        checkOutput("hi_window_peak_lit", 32'(peak), 32'd1800);
        send_samples(2047, SETTLEN);
        checkOutput("settle_clip_gain_lit", 32'(gain), 32'd19);

        send_samples(500, 4);
        d_in  = -12'sd2048;
        d_clk = 1'b1;
        tick();
        model_event(-2048);
        checkOutput("clip_pulse_lit", 32'(clip), 32'd1);
        checkOutput("clip_gain_lit", 32'(gain), 32'd18);
        checkOutput("clip_peak_lit", 32'(peak), 32'd2047);
        tick();
        d_clk = 1'b0;
        tick();
        tick();
        send_samples(0, SETTLEN);

        applyStimulus(100, 10);
        send_samples(100, WIN - 1);
        send_samples(100, 2 * WIN);
        checkOutput("hold3_gain_lit", 32'(gain), 32'd18);
        send_samples(1000, WIN);
        send_samples(100, 3 * WIN);
        checkOutput("hold_reset_gain_lit", 32'(gain), 32'd18);
        send_samples(100, WIN);
        checkOutput("hold4_gain_lit", 32'(gain), 32'd19);
        checkOutput("hold4_peak_lit", 32'(peak), 32'd100);

        applyStimulus(0, 2);
        do_reset();
        checkOutput("rst_settle_gain_lit", 32'(gain), 32'd20);
        checkOutput("rst_settle_upd_lit", 32'(gain_upd), 32'd0);
        checkOutput("rst_settle_clip_lit", 32'(clip), 32'd0);

        enter_manual(60);
        tick();
        tick();
        checkOutput("manual_clamp_lit", 32'(gain), 32'd52);
        manual_gain = 8'd30;
        tick();
        checkOutput("manual_follow_lit", 32'(gain), 32'd30);
        manual_gain = 8'd52;
        tick();
        tick();
        enter_agc();
        send_samples(100, HOLDW * WIN);
        checkOutput("gain_max_hold_lit", 32'(gain), 32'd52);

        send_samples(500, 100);
        enter_manual(0);
        tick();
        tick();
        checkOutput("drop_mid_window_lit", 32'(gain), 32'd0);
        enter_agc();
        applyStimulus(-2048, 2);
        checkOutput("gain_min_clip_lit", 32'(gain), 32'd0);
        applyStimulus(2047, 2);
        applyStimulus(0, 2);
        applyStimulus(2047, 2);
        checkOutput("gain_min_stays_lit", 32'(gain), 32'd0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
